mem_port_arbiter: RTL and testbench

//  Shares one single-ported, latency-based memory (req/we/addr/wdata in; rdata/busy/valid out)

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_port_arbiter_if.sv | 41 ++++
 rtl/mem_arb_pick.sv | 30 +++
 rtl/mem_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  // Watchdog sized so it can count up to TIMEOUT without wrapping.
  function automatic int wd_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the I-port, D-port and memory-side signals around the arbiter.
// slave = arbiter view, master = core/memory view.
interface mem_port_arbiter_if;

  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        i_err;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        d_err;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_busy;
  logic        mem_valid;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
           mem_rdata, mem_busy, mem_valid,
    output i_rdata, i_ack, i_err, d_rdata, d_ack, d_err,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
           mem_rdata, mem_busy, mem_valid,
    input  i_rdata, i_ack, i_err, d_rdata, d_ack, d_err,
           mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between the I and D ports.
// Round-robin on ties when MEM_ARB_RR_EN is defined, otherwise D has fixed priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
`ifdef MEM_ARB_RR_EN
  input  owner_t rr_ptr,
`endif
  output owner_t grant
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    grant = OWN_D;
    if (i_req && d_req) begin
      grant = rr_ptr;
    end else if (i_req) begin
      grant = OWN_I;
    end
  end
`else
  // D wins whenever it asks; a stalled MEM stage must not starve behind fetch.
  always_comb begin
    grant = (d_req || !i_req) ? OWN_D : OWN_I;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one latency-based memory between the I (read-only) and D (read/write) ports,
// one transaction at a time, with a watchdog. Optional round-robin: MEM_ARB_RR_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          TIMEOUT  = 64,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input logic                clk,
  input logic                rst_n,
  mem_port_arbiter_if.slave  bus
);

  localparam int             WD_W    = wd_width(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_t          state_q, state_nx;
  owner_t          owner_q, owner_nx;
  owner_t          grant;
  logic [WD_W-1:0] wd_q, wd_nx;

  logic            mem_req_q, mem_req_nx;
  logic            mem_we_q, mem_we_nx;
  logic [31:0]     mem_addr_q, mem_addr_nx;
  logic [31:0]     mem_wdata_q, mem_wdata_nx;

  logic            i_ack_q, i_ack_nx;
  logic            i_err_q, i_err_nx;
  logic [31:0]     i_rdata_q, i_rdata_nx;
  logic            d_ack_q, d_ack_nx;
  logic            d_err_q, d_err_nx;
  logic [31:0]     d_rdata_q, d_rdata_nx;

  logic            fin;
  logic            fin_err;
  logic [31:0]     fin_data;

`ifdef MEM_ARB_RR_EN
  owner_t          rr_q, rr_nx;
`endif

  mem_arb_pick u_pick (
    .i_req (bus.i_req),
    .d_req (bus.d_req),
`ifdef MEM_ARB_RR_EN
    .rr_ptr(rr_q),
`endif
    .grant (grant)
  );

  always_comb begin
    state_nx     = state_q;
    owner_nx     = owner_q;
    wd_nx        = wd_q;
    mem_req_nx   = 1'b0;
    mem_we_nx    = mem_we_q;
    mem_addr_nx  = mem_addr_q;
    mem_wdata_nx = mem_wdata_q;
    i_ack_nx     = 1'b0;
    i_err_nx     = 1'b0;
    i_rdata_nx   = i_rdata_q;
    d_ack_nx     = 1'b0;
    d_err_nx     = 1'b0;
    d_rdata_nx   = d_rdata_q;
    fin          = 1'b0;
    fin_err      = 1'b0;
    fin_data     = 32'h0;
`ifdef MEM_ARB_RR_EN
    rr_nx        = rr_q;
`endif

    unique case (state_q)
      IDLE: begin
        // Late mem_valid from an aborted transaction is ignored; only !mem_busy gates issue.
        if ((bus.i_req || bus.d_req) && !bus.mem_busy) begin
          owner_nx   = grant;
          mem_req_nx = 1'b1;
          wd_nx      = '0;
          state_nx   = WAIT;
          if (grant == OWN_D) begin
            mem_we_nx    = bus.d_we;
            mem_addr_nx  = bus.d_addr;
            mem_wdata_nx = bus.d_wdata;
          end else begin
            mem_we_nx    = 1'b0;
            mem_addr_nx  = bus.i_addr;
            mem_wdata_nx = 32'h0;
          end
`ifdef MEM_ARB_RR_EN
          rr_nx = (grant == OWN_D) ? OWN_I : OWN_D;
`endif
        end
      end
      WAIT: begin
        if (bus.mem_valid) begin
          fin      = 1'b1;
          fin_data = mem_we_q ? 32'h0 : bus.mem_rdata;
          state_nx = DONE;
        end else if (wd_q == WD_LAST) begin
          fin      = 1'b1;
          fin_err  = 1'b1;
          fin_data = mem_we_q ? 32'h0 : ERR_DATA;
          state_nx = DONE;
        end else begin
          wd_nx = wd_q + WD_W'(1);
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    if (fin) begin
      if (owner_q == OWN_D) begin
        d_ack_nx   = 1'b1;
        d_err_nx   = fin_err;
        d_rdata_nx = fin_data;
      end else begin
        i_ack_nx   = 1'b1;
        i_err_nx   = fin_err;
        i_rdata_nx = fin_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_I;
      wd_q        <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      i_ack_q     <= 1'b0;
      i_err_q     <= 1'b0;
      i_rdata_q   <= 32'h0;
      d_ack_q     <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= 32'h0;
`ifdef MEM_ARB_RR_EN
      rr_q        <= OWN_D;
`endif
    end else begin
      state_q     <= state_nx;
      owner_q     <= owner_nx;
      wd_q        <= wd_nx;
      mem_req_q   <= mem_req_nx;
      mem_we_q    <= mem_we_nx;
      mem_addr_q  <= mem_addr_nx;
      mem_wdata_q <= mem_wdata_nx;
      i_ack_q     <= i_ack_nx;
      i_err_q     <= i_err_nx;
      i_rdata_q   <= i_rdata_nx;
      d_ack_q     <= d_ack_nx;
      d_err_q     <= d_err_nx;
      d_rdata_q   <= d_rdata_nx;
`ifdef MEM_ARB_RR_EN
      rr_q        <= rr_nx;
`endif
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.i_ack     = i_ack_q;
  assign bus.i_err     = i_err_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_err     = d_err_q;
  assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a LATENCY=3 memory model and TIMEOUT=8.
module tb_mem_port_arbiter;

  localparam int LAT = 3;

  logic clk;
  logic rst_n;
  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.TIMEOUT(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: responds LAT edges after seeing mem_req; can hang or be forced busy.
  logic [31:0] mem [0:63];
  logic        m_busy, m_valid, hang, busy_force;
  logic [31:0] m_rdata;
  int          m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_rdata <= 32'h0;
      m_cnt   <= 0;
      for (int k = 0; k < 64; k++) mem[k] <= 32'hA500_0000 | 32'(k);
      mem[4] <= 32'hCAFE_0001;
    end else begin
      m_valid <= 1'b0;
      if (bus.mem_req && !hang) begin
        m_busy <= 1'b1;
        m_cnt  <= LAT;
      end else if (m_cnt > 1) begin
        m_cnt <= m_cnt - 1;
      end else if (m_cnt == 1) begin
        m_cnt   <= 0;
        m_busy  <= 1'b0;
        m_valid <= 1'b1;
        if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
        else            m_rdata <= mem[bus.mem_addr[7:2]];
      end
    end
  end

  assign bus.mem_busy  = m_busy | busy_force;
  assign bus.mem_valid = m_valid;
  assign bus.mem_rdata = m_rdata;

  // Issue log sampled on the falling edge.
  int          req_cnt;
  logic [31:0] issue_q [$];
  always @(negedge clk) begin
    if (bus.mem_req) begin
      req_cnt++;
      issue_q.push_back(bus.mem_addr);
    end
  end

  int checks;
  int failures;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ack(input bit port_d, input int bound, output int cyc);
    cyc = 0;
    while (!(port_d ? bus.d_ack : bus.i_ack) && cyc < bound) begin
      step(1);
      cyc++;
    end
  endtask

  int          cyc;
  int          base;
  logic [31:0] exp_seq [4];

  initial begin
    checks = 0; failures = 0; req_cnt = 0;
    hang = 1'b0; busy_force = 1'b0;
    bus.i_req = 1'b0; bus.i_addr = 32'h0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);

    chk("reset_mem_req", bus.mem_req, 0);
    chk("reset_mem_addr", bus.mem_addr, 32'h0);
    chk("reset_d_ack", bus.d_ack, 0);
    chk("reset_i_rdata", bus.i_rdata, 32'h0);

    // 1: D read of 0x10
    base = req_cnt;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h10;
    step(1);
    chk("t1_mem_req_grant", bus.mem_req, 1);
    chk("t1_mem_addr", bus.mem_addr, 32'h10);
    wait_ack(1'b1, 20, cyc);
    chk("t1_ack_latency", cyc, 5);
    chk("t1_d_ack", bus.d_ack, 1);
    chk("t1_d_rdata", bus.d_rdata, 32'hCAFE_0001);
    chk("t1_d_err", bus.d_err, 0);
    chk("t1_i_ack", bus.i_ack, 0);
    chk("t1_req_pulses", req_cnt - base, 1);
    bus.d_req = 1'b0;
    step(1);
    chk("t1_ack_one_cycle", bus.d_ack, 0);

    // 2: D write 0x20 then I read 0x20
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h20; bus.d_wdata = 32'h1234_5678;
    step(1);
    chk("t2_mem_we", bus.mem_we, 1);
    chk("t2_mem_wdata", bus.mem_wdata, 32'h1234_5678);
    wait_ack(1'b1, 20, cyc);
    chk("t2_d_ack", bus.d_ack, 1);
    chk("t2_d_err", bus.d_err, 0);
    chk("t2_d_rdata_write", bus.d_rdata, 32'h0);
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    step(1);
    bus.i_req = 1'b1; bus.i_addr = 32'h20;
    step(1);
    chk("t2_i_mem_we", bus.mem_we, 0);
    chk("t2_i_mem_wdata", bus.mem_wdata, 32'h0);
    wait_ack(1'b0, 20, cyc);
    chk("t2_i_ack", bus.i_ack, 1);
    chk("t2_i_rdata", bus.i_rdata, 32'h1234_5678);
    chk("t2_i_err", bus.i_err, 0);
    bus.i_req = 1'b0;
    step(2);

    // 6: mem_busy forced high holds off the issue
    base = req_cnt;
    busy_force = 1'b1;
    bus.i_req = 1'b1; bus.i_addr = 32'h4;
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk("t6_no_req_while_busy", bus.mem_req, 0);
    end
    busy_force = 1'b0;
    step(1);
    chk("t6_req_after_busy", bus.mem_req, 1);
    wait_ack(1'b0, 20, cyc);
    chk("t6_i_ack", bus.i_ack, 1);
    chk("t6_i_rdata", bus.i_rdata, 32'hA500_0001);
    chk("t6_req_pulses", req_cnt - base, 1);
    bus.i_req = 1'b0;
    step(2);

    // 4: hung memory -> timeout
    hang = 1'b1;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0;
    step(1);
    chk("t4_mem_req", bus.mem_req, 1);
    wait_ack(1'b1, 30, cyc);
    chk("t4_timeout_cycles", cyc, 8);
    chk("t4_d_ack", bus.d_ack, 1);
    chk("t4_d_err", bus.d_err, 1);
    chk("t4_d_rdata", bus.d_rdata, 32'hDEAD_BEEF);
    bus.d_req = 1'b0;
    hang = 1'b0;
    step(1);
    chk("t4_err_cleared", bus.d_err, 0);
    step(1);

    // 5: reset while in WAIT
    bus.i_req = 1'b1; bus.i_addr = 32'h8;
    step(1);
    chk("t5_pre_reset_req", bus.mem_req, 1);
    rst_n = 1'b0;
    bus.i_req = 1'b0;
    #1;
    chk("t5_reset_mem_req", bus.mem_req, 0);
    chk("t5_reset_mem_addr", bus.mem_addr, 32'h0);
    chk("t5_reset_d_rdata", bus.d_rdata, 32'h0);
    step(2);
    rst_n = 1'b1;
    step(1);
    bus.i_req = 1'b1; bus.i_addr = 32'h4;
    wait_ack(1'b0, 20, cyc);
    chk("t5_post_latency", cyc, 6);
    chk("t5_post_i_rdata", bus.i_rdata, 32'hA500_0001);
    chk("t5_post_i_err", bus.i_err, 0);
    bus.i_req = 1'b0;
    step(2);

    // 3: simultaneous, held requests for four transactions
`ifdef MEM_ARB_RR_EN
    exp_seq = '{32'h200, 32'h100, 32'h200, 32'h100};
`else
    exp_seq = '{32'h200, 32'h200, 32'h200, 32'h200};
`endif
    issue_q.delete();
    bus.i_req = 1'b1; bus.i_addr = 32'h100;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200;
    cyc = 0;
    while (issue_q.size() < 4 && cyc < 60) begin
      step(1);
      cyc++;
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    chk("t3_issue_count", issue_q.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t3_grant_%0d", k),
          (k < issue_q.size()) ? issue_q[k] : 32'hFFFF_FFFF, exp_seq[k]);
    end
    step(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
